// File: rtl/fetch_pkg.sv
// Shared state type and constants for the instruction fetch unit.
// Defining FETCH_FAULT_CHECK_EN adds the FAULT state used by fetch address checking.
package fetch_pkg;

    localparam logic [31:0] DEFAULT_RESET_PC  = 32'h0040_0000;
    localparam logic [31:0] DEFAULT_TEXT_BASE = 32'h0040_0000;
    localparam int unsigned PC_INCR           = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
`ifdef FETCH_FAULT_CHECK_EN
        HOLD  = 2'd2,
        FAULT = 2'd3
`else
        HOLD  = 2'd2
`endif
    } fetch_state_e;

endpackage

// File: rtl/fetch_port_mux.sv
// Single memory port arbitration: a pending data access always wins over the
// instruction fetch address.
module fetch_port_mux #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  dmem_req_i,
    input  logic                  dmem_we_i,
    input  logic [DATA_WIDTH-1:0] dmem_addr_i,
    input  logic [DATA_WIDTH-1:0] dmem_wdata_i,
    input  logic [DATA_WIDTH-1:0] fetch_addr_i,
    output logic [DATA_WIDTH-1:0] mem_addr_o,
    output logic                  mem_we_o,
    output logic [DATA_WIDTH-1:0] mem_wdata_o
);

    always_comb begin
        mem_addr_o  = fetch_addr_i;
        mem_we_o    = 1'b0;
        mem_wdata_o = '0;
        if (dmem_req_i) begin
            mem_addr_o  = dmem_addr_i;
            mem_we_o    = dmem_we_i;
            mem_wdata_o = dmem_wdata_i;
        end
    end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: owns the PC, shares the memory port with data accesses and hands
// captured instructions downstream through a valid/ready IR. Optional macro: FETCH_FAULT_CHECK_EN.
module instruction_fetch_unit
    import fetch_pkg::*;
#(
    parameter int                    DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_PC   = DATA_WIDTH'(DEFAULT_RESET_PC),
    parameter logic [DATA_WIDTH-1:0] TEXT_BASE  = DATA_WIDTH'(DEFAULT_TEXT_BASE),
    parameter int                    TEXT_DEPTH = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    output logic [DATA_WIDTH-1:0] mem_addr_o,
    output logic                  mem_we_o,
    output logic [DATA_WIDTH-1:0] mem_wdata_o,
    input  logic [DATA_WIDTH-1:0] mem_rdata_i,
    input  logic                  dmem_req_i,
    input  logic                  dmem_we_i,
    input  logic [DATA_WIDTH-1:0] dmem_addr_i,
    input  logic [DATA_WIDTH-1:0] dmem_wdata_i,
    input  logic                  redirect_i,
    input  logic [DATA_WIDTH-1:0] redirect_pc_i,
    output logic [DATA_WIDTH-1:0] ir_o,
    output logic [DATA_WIDTH-1:0] pc_o,
    output logic [DATA_WIDTH-1:0] pc_plus4_o,
    output logic                  ir_valid_o,
    input  logic                  ir_ready_i,
    output logic                  fault_o
);

    fetch_state_e          state_q;
    logic [DATA_WIDTH-1:0] pc_q;
    logic [DATA_WIDTH-1:0] ir_q;
    logic [DATA_WIDTH-1:0] pcOut_q;
    logic                  irValid_q;
    logic [DATA_WIDTH-1:0] pcIncr;

    assign pcIncr = pc_q + DATA_WIDTH'(PC_INCR);

`ifdef FETCH_FAULT_CHECK_EN
    localparam logic [DATA_WIDTH-1:0] TEXT_END = TEXT_BASE + DATA_WIDTH'(4 * TEXT_DEPTH);

    logic fault_q;
    logic fetchFault;

    assign fetchFault = (pc_q[1:0] != 2'b00) || (pc_q < TEXT_BASE) || (pc_q >= TEXT_END);
    assign fault_o    = fault_q;
`else
    assign fault_o = 1'b0;
`endif

    // Redirect outranks every state so a taken branch never lets a stale fetch through.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            pc_q      <= RESET_PC;
            ir_q      <= '0;
            pcOut_q   <= RESET_PC;
            irValid_q <= 1'b0;
`ifdef FETCH_FAULT_CHECK_EN
            fault_q   <= 1'b0;
`endif
        end else if (redirect_i) begin
            pc_q      <= redirect_pc_i;
            irValid_q <= 1'b0;
            state_q   <= FETCH;
`ifdef FETCH_FAULT_CHECK_EN
            fault_q   <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: state_q <= FETCH;
                FETCH: begin
                    if (!dmem_req_i) begin
`ifdef FETCH_FAULT_CHECK_EN
                        if (fetchFault) begin
                            state_q <= FAULT;
                            fault_q <= 1'b1;
                        end else
`endif
                        begin
                            ir_q      <= mem_rdata_i;
                            pcOut_q   <= pc_q;
                            pc_q      <= pcIncr;
                            irValid_q <= 1'b1;
                            state_q   <= HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (ir_ready_i) begin
                        irValid_q <= 1'b0;
                        state_q   <= FETCH;
                    end
                end
`ifdef FETCH_FAULT_CHECK_EN
                FAULT: state_q <= FAULT;
`endif
                default: state_q <= IDLE;
            endcase
        end
    end

    assign ir_o       = ir_q;
    assign pc_o       = pcOut_q;
    assign pc_plus4_o = pcOut_q + DATA_WIDTH'(PC_INCR);
    assign ir_valid_o = irValid_q;

    fetch_port_mux #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_port_mux (
        .dmem_req_i  (dmem_req_i),
        .dmem_we_i   (dmem_we_i),
        .dmem_addr_i (dmem_addr_i),
        .dmem_wdata_i(dmem_wdata_i),
        .fetch_addr_i(pc_q),
        .mem_addr_o  (mem_addr_o),
        .mem_we_o    (mem_we_o),
        .mem_wdata_o (mem_wdata_o)
    );

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit: a vector table for the main fetch /
// stall / redirect flow plus hand sequences for wrap, misaligned fetch and reset.
module tb_instruction_fetch_unit;

    logic        clk;
    logic        reset;
    logic [31:0] memAddr;
    logic        memWe;
    logic [31:0] memWdata;
    logic [31:0] memRdata;
    logic        dmemReq;
    logic        dmemWe;
    logic [31:0] dmemAddr;
    logic [31:0] dmemWdata;
    logic        redirect;
    logic [31:0] redirectPc;
    logic [31:0] ir;
    logic [31:0] pcOut;
    logic [31:0] pcPlus4;
    logic        irValid;
    logic        irReady;
    logic        fault;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        redirect;
        logic [31:0] redirectPc;
        logic        ready;
        logic        req;
        logic        we;
        logic [31:0] dAddr;
        logic [31:0] dWdata;
        logic        expValid;
        logic [31:0] expIr;
        logic [31:0] expPc;
        logic [31:0] expAddr;
        logic        expWe;
    } vec_t;

    vec_t vecs[17];

    instruction_fetch_unit dut (
        .clk          (clk),
        .reset        (reset),
        .mem_addr_o   (memAddr),
        .mem_we_o     (memWe),
        .mem_wdata_o  (memWdata),
        .mem_rdata_i  (memRdata),
        .dmem_req_i   (dmemReq),
        .dmem_we_i    (dmemWe),
        .dmem_addr_i  (dmemAddr),
        .dmem_wdata_i (dmemWdata),
        .redirect_i   (redirect),
        .redirect_pc_i(redirectPc),
        .ir_o         (ir),
        .pc_o         (pcOut),
        .pc_plus4_o   (pcPlus4),
        .ir_valid_o   (irValid),
        .ir_ready_i   (irReady),
        .fault_o      (fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: word0 is a real instruction, every other address returns a tag of itself.
    function automatic logic [31:0] romWord(input logic [31:0] addr);
        if (addr == 32'h0040_0000) return 32'h2008_0005;
        return {16'hC0DE, addr[15:0]};
    endfunction

    always_comb memRdata = romWord(memAddr);

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        redirect   = v.redirect;
        redirectPc = v.redirectPc;
        irReady    = v.ready;
        dmemReq    = v.req;
        dmemWe     = v.we;
        dmemAddr   = v.dAddr;
        dmemWdata  = v.dWdata;
    endtask

    task automatic nextCycle();
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    initial begin
        vecs[0]  = '{1'b0, 32'h0,         1'b1, 1'b0, 1'b0, 32'h0,         32'h0,         1'b0, 32'h0,         32'h0040_0000, 32'h0040_0000, 1'b0};
        vecs[1]  = '{1'b0, 32'h0,         1'b1, 1'b0, 1'b0, 32'h0,         32'h0,         1'b0, 32'h0,         32'h0040_0000, 32'h0040_0000, 1'b0};
        for (int i = 2; i <= 6; i++)
            vecs[i] = '{1'b0, 32'h0,      1'b0, 1'b0, 1'b0, 32'h0,         32'h0,         1'b1, 32'h2008_0005, 32'h0040_0000, 32'h0040_0004, 1'b0};
        vecs[7]  = '{1'b0, 32'h0,         1'b1, 1'b0, 1'b0, 32'h0,         32'h0,         1'b1, 32'h2008_0005, 32'h0040_0000, 32'h0040_0004, 1'b0};
        vecs[8]  = '{1'b0, 32'h0,         1'b0, 1'b1, 1'b1, 32'h1001_0000, 32'h1234_5678, 1'b0, 32'h2008_0005, 32'h0040_0000, 32'h1001_0000, 1'b1};
        vecs[9]  = '{1'b0, 32'h0,         1'b0, 1'b1, 1'b0, 32'h1001_0004, 32'h0,         1'b0, 32'h2008_0005, 32'h0040_0000, 32'h1001_0004, 1'b0};
        vecs[10] = '{1'b0, 32'h0,         1'b1, 1'b0, 1'b0, 32'h0,         32'h0,         1'b0, 32'h2008_0005, 32'h0040_0000, 32'h0040_0004, 1'b0};
        vecs[11] = '{1'b1, 32'h0040_0010, 1'b0, 1'b0, 1'b0, 32'h0,         32'h0,         1'b1, 32'hC0DE_0004, 32'h0040_0004, 32'h0040_0008, 1'b0};
        vecs[12] = '{1'b0, 32'h0,         1'b1, 1'b0, 1'b0, 32'h0,         32'h0,         1'b0, 32'hC0DE_0004, 32'h0040_0004, 32'h0040_0010, 1'b0};
        vecs[13] = '{1'b1, 32'h0040_0020, 1'b1, 1'b0, 1'b0, 32'h0,         32'h0,         1'b1, 32'hC0DE_0010, 32'h0040_0010, 32'h0040_0014, 1'b0};
        vecs[14] = '{1'b1, 32'h0040_0030, 1'b0, 1'b1, 1'b1, 32'h1001_0008, 32'hAABB_CCDD, 1'b0, 32'hC0DE_0010, 32'h0040_0010, 32'h1001_0008, 1'b1};
        vecs[15] = '{1'b0, 32'h0,         1'b0, 1'b0, 1'b0, 32'h0,         32'h0,         1'b0, 32'hC0DE_0010, 32'h0040_0010, 32'h0040_0030, 1'b0};
        vecs[16] = '{1'b0, 32'h0,         1'b1, 1'b0, 1'b0, 32'h0,         32'h0,         1'b1, 32'hC0DE_0030, 32'h0040_0030, 32'h0040_0034, 1'b0};

        reset      = 1'b0;
        redirect   = 1'b0;
        redirectPc = '0;
        irReady    = 1'b0;
        dmemReq    = 1'b0;
        dmemWe     = 1'b0;
        dmemAddr   = '0;
        dmemWdata  = '0;

        // Reset state
        nextCycle();
        checkOutput("rst ir_valid", {31'b0, irValid}, 32'h0);
        checkOutput("rst ir", ir, 32'h0);
        checkOutput("rst pc", pcOut, 32'h0040_0000);
        checkOutput("rst pc_plus4", pcPlus4, 32'h0040_0004);
        checkOutput("rst fault", {31'b0, fault}, 32'h0);
        checkOutput("rst mem_we", {31'b0, memWe}, 32'h0);
        checkOutput("rst mem_addr", memAddr, 32'h0040_0000);

        @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i < 17; i++) begin
            applyStimulus(vecs[i]);
            #1;
            checkOutput($sformatf("v%0d ir_valid", i), {31'b0, irValid}, {31'b0, vecs[i].expValid});
            checkOutput($sformatf("v%0d ir", i), ir, vecs[i].expIr);
            checkOutput($sformatf("v%0d pc", i), pcOut, vecs[i].expPc);
            checkOutput($sformatf("v%0d pc_plus4", i), pcPlus4, vecs[i].expPc + 32'd4);
            checkOutput($sformatf("v%0d mem_addr", i), memAddr, vecs[i].expAddr);
            checkOutput($sformatf("v%0d mem_we", i), {31'b0, memWe}, {31'b0, vecs[i].expWe});
            checkOutput($sformatf("v%0d mem_wdata", i), memWdata, vecs[i].req ? vecs[i].dWdata : 32'h0);
            checkOutput($sformatf("v%0d fault", i), {31'b0, fault}, 32'h0);
            @(posedge clk);
            @(negedge clk);
        end

        // PC wrap: fetch at 0xFFFFFFFC leaves the next PC at 0
        redirect   = 1'b1;
        redirectPc = 32'hFFFF_FFFC;
        irReady    = 1'b0;
        nextCycle();
        redirect = 1'b0;
        #1;
        checkOutput("wrap mem_addr", memAddr, 32'hFFFF_FFFC);
        checkOutput("wrap ir_valid pre", {31'b0, irValid}, 32'h0);
        nextCycle();
`ifdef FETCH_FAULT_CHECK_EN
        checkOutput("wrap fault", {31'b0, fault}, 32'h1);
        checkOutput("wrap ir_valid", {31'b0, irValid}, 32'h0);
`else
        checkOutput("wrap ir_valid", {31'b0, irValid}, 32'h1);
        checkOutput("wrap ir", ir, 32'hC0DE_FFFC);
        checkOutput("wrap pc", pcOut, 32'hFFFF_FFFC);
        checkOutput("wrap pc_plus4", pcPlus4, 32'h0);
        checkOutput("wrap next pc", memAddr, 32'h0);
`endif

        // Misaligned redirect target
        redirect   = 1'b1;
        redirectPc = 32'h0040_0002;
        nextCycle();
        redirect = 1'b0;
        #1;
        checkOutput("misal mem_addr", memAddr, 32'h0040_0002);
        checkOutput("misal fault pre", {31'b0, fault}, 32'h0);
        checkOutput("misal ir_valid pre", {31'b0, irValid}, 32'h0);
        nextCycle();
`ifdef FETCH_FAULT_CHECK_EN
        checkOutput("misal fault", {31'b0, fault}, 32'h1);
        checkOutput("misal ir_valid", {31'b0, irValid}, 32'h0);
        irReady = 1'b1;
        nextCycle();
        nextCycle();
        nextCycle();
        checkOutput("misal fault held", {31'b0, fault}, 32'h1);
        checkOutput("misal ir_valid held", {31'b0, irValid}, 32'h0);
        irReady = 1'b0;
`else
        checkOutput("misal fault", {31'b0, fault}, 32'h0);
        checkOutput("misal ir_valid", {31'b0, irValid}, 32'h1);
        checkOutput("misal ir", ir, 32'hC0DE_0002);
        checkOutput("misal pc", pcOut, 32'h0040_0002);
`endif

        // Redirect back to the text base resumes normal fetch
        redirect   = 1'b1;
        redirectPc = 32'h0040_0000;
        nextCycle();
        redirect = 1'b0;
        #1;
        checkOutput("resume fault", {31'b0, fault}, 32'h0);
        checkOutput("resume ir_valid pre", {31'b0, irValid}, 32'h0);
        nextCycle();
        checkOutput("resume ir_valid", {31'b0, irValid}, 32'h1);
        checkOutput("resume ir", ir, 32'h2008_0005);
        checkOutput("resume pc", pcOut, 32'h0040_0000);

        // Reset asserted in the middle of a data-stalled fetch
        irReady = 1'b1;
        nextCycle();
        irReady   = 1'b0;
        dmemReq   = 1'b1;
        dmemWe    = 1'b1;
        dmemAddr  = 32'h1001_0010;
        dmemWdata = 32'h0BAD_F00D;
        nextCycle();
        nextCycle();
        reset = 1'b0;
        #1;
        checkOutput("midrst ir_valid", {31'b0, irValid}, 32'h0);
        checkOutput("midrst ir", ir, 32'h0);
        checkOutput("midrst pc", pcOut, 32'h0040_0000);
        checkOutput("midrst mem_addr dmem", memAddr, 32'h1001_0010);
        dmemReq = 1'b0;
        dmemWe  = 1'b0;
        #1;
        checkOutput("midrst mem_addr pc", memAddr, 32'h0040_0000);
        checkOutput("midrst mem_we", {31'b0, memWe}, 32'h0);
        nextCycle();
        @(negedge clk);
        reset = 1'b1;
        nextCycle();
        checkOutput("rerst ir_valid edge1", {31'b0, irValid}, 32'h0);
        nextCycle();
        checkOutput("rerst ir_valid edge2", {31'b0, irValid}, 32'h1);
        checkOutput("rerst ir", ir, 32'h2008_0005);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
